// File: rtl/busctrl_tmo.sv
// System bus controller: parametrised address decode from the CPU master to NSLV slaves,
// with a per-access timeout watchdog, bus-error response and fault capture.
module busctrl_tmo #(
  parameter int unsigned        NSLV       = 8,
  parameter logic [NSLV*32-1:0] SLV_BASE   = '0,
  parameter logic [NSLV*32-1:0] SLV_MASK   = '0,
  parameter int unsigned        TMO_CYCLES = 256,
  parameter int unsigned        CNT_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cpu_en,
  input  logic                 cpu_wr,
  input  logic [1:0]           cpu_size,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_data_out,
  output logic [31:0]          cpu_data_in,
  output logic                 cpu_wt,
  output logic                 cpu_berr,
  output logic [NSLV-1:0]      slv_en,
  output logic                 slv_wr,
  output logic [1:0]           slv_size,
  output logic [31:0]          slv_addr,
  output logic [31:0]          slv_data_out,
  input  logic [NSLV*32-1:0]   slv_data_in,
  input  logic [NSLV-1:0]      slv_wt,
  output logic [31:0]          err_addr,
  output logic                 err_kind,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int unsigned IdxW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int unsigned TmoW = $clog2(TMO_CYCLES);

  typedef enum logic [1:0] {StIdle, StBusy, StErr} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   sel_q, sel_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic              kind_q, kind_d;
  logic [31:0]       err_addr_q, err_addr_d;
  logic              err_kind_q, err_kind_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic              hit;
  logic [IdxW-1:0]   hit_idx;
  logic [IdxW-1:0]   addr_idx;

  // Scan from the top so the lowest matching slot is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = int'(NSLV) - 1; i >= 0; i--) begin
      if ((cpu_addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit     = 1'b1;
        hit_idx = IdxW'(i);
      end
    end
  end

  assign addr_idx     = (state_q == StBusy) ? sel_q : hit_idx;
  assign slv_addr     = cpu_addr & ~SLV_MASK[{addr_idx, 5'd0} +: 32];
  assign slv_wr       = cpu_wr;
  assign slv_size     = cpu_size;
  assign slv_data_out = cpu_data_out;

  assign err_addr = err_addr_q;
  assign err_kind = err_kind_q;
  assign err_cnt  = err_cnt_q;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    tmo_d       = tmo_q;
    kind_d      = kind_q;
    err_addr_d  = err_addr_q;
    err_kind_d  = err_kind_q;
    err_cnt_d   = err_cnt_q;
    cpu_wt      = 1'b1;
    cpu_berr    = 1'b0;
    cpu_data_in = '0;
    slv_en      = '0;

    unique case (state_q)
      StIdle: begin
        if (cpu_en) begin
          if (hit) begin
            sel_d   = hit_idx;
            tmo_d   = '0;
            state_d = StBusy;
          end else begin
            kind_d  = 1'b0;
            state_d = StErr;
          end
        end
      end
      StBusy: begin
        cpu_data_in = slv_data_in[{sel_q, 5'd0} +: 32];
        if (!cpu_en) begin
          // Master abandoned the access: back off quietly, nothing is recorded.
          state_d = StIdle;
        end else begin
          slv_en[sel_q] = 1'b1;
          cpu_wt        = slv_wt[sel_q];
          if (!slv_wt[sel_q]) begin
            state_d = StIdle;
          end else if (tmo_q == TmoW'(TMO_CYCLES - 1)) begin
            kind_d  = 1'b1;
            state_d = StErr;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      StErr: begin
        cpu_wt     = 1'b0;
        cpu_berr   = 1'b1;
        err_addr_d = cpu_addr;
        err_kind_d = kind_q;
        if (err_cnt_q != '1) begin
          err_cnt_d = err_cnt_q + 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      sel_q      <= '0;
      tmo_q      <= '0;
      kind_q     <= 1'b0;
      err_addr_q <= '0;
      err_kind_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      tmo_q      <= tmo_d;
      kind_q     <= kind_d;
      err_addr_q <= err_addr_d;
      err_kind_q <= err_kind_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

endmodule
